// File: rtl/shift_pkg.sv
// Op codes and decode helpers shared by the pipelined shift/rotate unit.
package shift_pkg;

  typedef logic [2:0] shift_op_t;

  localparam shift_op_t OP_SLL = 3'd0;
  localparam shift_op_t OP_SRL = 3'd1;
  localparam shift_op_t OP_SLA = 3'd2;
  localparam shift_op_t OP_SRA = 3'd3;
  localparam shift_op_t OP_ROL = 3'd4;
  localparam shift_op_t OP_ROR = 3'd5;

  function automatic logic is_right(input shift_op_t op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  function automatic logic is_arith(input shift_op_t op);
    return (op == OP_SLA) || (op == OP_SRA);
  endfunction

  function automatic logic is_rotate(input shift_op_t op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel level: shifts or rotates by DIST bit positions when en is set,
// filling vacated positions with fill for plain shifts.
module shift_stage #(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             right,
  input  logic             rotate,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  logic [DIST-1:0] fill_bits;
  logic [DIST-1:0] right_in;
  logic [DIST-1:0] left_in;

  assign fill_bits = {DIST{fill}};
  assign right_in  = rotate ? data[DIST-1:0] : fill_bits;
  assign left_in   = rotate ? data[WIDTH-1:WIDTH-DIST] : fill_bits;

  assign result = !en   ? data :
                  right ? {right_in, data[WIDTH-1:DIST]} :
                          {data[WIDTH-DIST-1:0], left_in};

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage valid/ready shift/rotate unit (S1 operands, S2 result).
// Define SHIFT_FLAGS_EN to add the registered out_zero/out_carry flags.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef SHIFT_FLAGS_EN
  ,
  output logic               out_zero,
  output logic               out_carry
`endif
);

  localparam int LEVELS = $clog2(WIDTH);

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_data;
  logic [SHAMT_W-1:0] s1_shamt;
  shift_op_t          s1_op;
  logic               s2_valid;
  logic               s1_adv;
  logic               s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  logic [31:0]              shamt_ext;
  logic                     rot;
  logic                     reserved;
  logic                     right;
  logic                     fill;
  logic                     oor;
  logic [LEVELS-1:0]        amt;
  logic [LEVELS:0][WIDTH-1:0] lvl;
  logic [WIDTH-1:0]         shift_res;

  assign shamt_ext = 32'(s1_shamt);
  assign rot       = is_rotate(s1_op);
  assign reserved  = (s1_op > OP_ROR);
  assign right     = is_right(s1_op);
  assign fill      = is_arith(s1_op) && right && s1_data[WIDTH-1];
  // Rotates wrap modulo WIDTH; plain shifts saturate once the amount reaches WIDTH.
  assign oor       = !rot && !reserved && (shamt_ext >= 32'(WIDTH));
  assign amt       = reserved ? '0 :
                     rot      ? LEVELS'(shamt_ext % 32'(WIDTH)) :
                                LEVELS'(shamt_ext);
  assign lvl[0]    = s1_data;

  for (genvar gi = 0; gi < LEVELS; gi++) begin : g_level
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (2 ** gi)
    ) u_stage (
      .data   (lvl[gi]),
      .en     (amt[gi]),
      .right  (right),
      .rotate (rot),
      .fill   (fill),
      .result (lvl[gi+1])
    );
  end

  assign shift_res = oor ? {WIDTH{fill}} : lvl[LEVELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_shamt <= '0;
      s1_op    <= OP_SLL;
      s2_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data  <= in_data;
          s1_shamt <= in_shamt;
          s1_op    <= in_op;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= shift_res;
        end
      end
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic carry_next;

  // Carry is the last bit pushed off the end; for rotates that bit re-enters
  // at the LSB (ROL) or MSB (ROR) of the result.
  always_comb begin
    carry_next = 1'b0;
    if (shamt_ext != 32'd0) begin
      case (s1_op)
        OP_SLL, OP_SLA: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (shamt_ext == 32'(WIDTH - i)) carry_next = s1_data[i];
          end
        end
        OP_SRL, OP_SRA: begin
          if (shamt_ext > 32'(WIDTH)) begin
            carry_next = fill;
          end else begin
            for (int i = 0; i < WIDTH; i++) begin
              if (shamt_ext == 32'(i + 1)) carry_next = s1_data[i];
            end
          end
        end
        OP_ROL:  carry_next = shift_res[0];
        OP_ROR:  carry_next = shift_res[WIDTH-1];
        default: carry_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      out_zero  <= (shift_res == '0);
      out_carry <= carry_next;
    end
  end
`endif

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe (WIDTH=8, SHAMT_W=4); builds with or
// without SHIFT_FLAGS_EN and checks the flags only when they exist.
module tb_shift_unit_pipe;

  localparam int W  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [2:0]    in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
`ifdef SHIFT_FLAGS_EN
  logic          out_zero;
  logic          out_carry;
`endif

  always #5 clk = ~clk;

  shift_unit_pipe #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFT_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_carry (out_carry)
`endif
  );

  typedef struct {
    logic [W-1:0] res;
    logic         car;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           fails = 0;
  int           cycle = 0;
  int           pushes = 0;
  int           pops = 0;
  int           st_start = 0;
  int           st_len = 0;
  bit           rand_mode = 1'b0;
  bit           lat_check = 1'b0;
  bit           hold_pend = 1'b0;
  bit           saw_block = 1'b0;
  logic [W-1:0] held_data;
  logic [8:0]   next_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: shifts done on wide integers so over-range amounts fall out naturally;
  // carry is the bit that crossed the operand boundary last.
  function automatic logic [8:0] model(input logic [7:0] d, input int s, input logic [2:0] op);
    logic [31:0]        u;
    logic signed [31:0] sg;
    logic [15:0]        rr;
    logic [7:0]         r;
    logic               c;
    int                 k;
    r = d;
    c = 1'b0;
    k = s % 8;
    case (op)
      3'd0, 3'd2: begin
        u = 32'(d) << s;
        r = u[7:0];
        c = (s != 0) && u[8];
      end
      3'd1: begin
        u = 32'(d) >> s;
        r = u[7:0];
        if (s != 0) begin
          u = 32'(d) >> (s - 1);
          c = u[0];
        end
      end
      3'd3: begin
        sg = 32'(signed'(d));
        u  = sg >>> s;
        r  = u[7:0];
        if (s != 0) begin
          u = sg >>> (s - 1);
          c = u[0];
        end
      end
      3'd4: begin
        rr = {d, d} << k;
        r  = rr[15:8];
        c  = (s != 0) && r[0];
      end
      3'd5: begin
        rr = {d, d} >> k;
        r  = rr[7:0];
        c  = (s != 0) && r[7];
      end
      default: ;
    endcase
    return {c, r};
  endfunction

  // One clock: sample and score at negedge, then advance to just after posedge.
  task automatic step(output bit took);
    exp_t e;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(out_ready || (q.size() < 2)));
    if (!in_ready) saw_block = 1'b1;
    if (hold_pend) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(held_data));
    end
    hold_pend = out_valid && !out_ready;
    held_data = out_data;
    if (out_valid && out_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL spurious_out: observed out_valid=1 with data %0h expected no output", out_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        pops++;
        $display("txn %0d: cycle %0d out_data=%02h expect=%02h", pops, cycle, out_data, e.res);
        check("data", 32'(out_data), 32'(e.res));
`ifdef SHIFT_FLAGS_EN
        check("zero", 32'(out_zero), 32'(e.res == '0));
        check("carry", 32'(out_carry), 32'(e.car));
`endif
        if (lat_check) check("latency", 32'(cycle - e.acc), 32'd2);
      end
    end
    took = in_valid && in_ready;
    if (took) begin
      q.push_back('{res: next_exp[7:0], car: next_exp[8], acc: cycle});
      pushes++;
    end
    @(posedge clk);
    #1;
    cycle++;
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) :
                !((cycle >= st_start) && (cycle < st_start + st_len));
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] s, input logic [2:0] op,
                      input bit lit, input logic [8:0] lit_exp);
    bit acc;
    bit took;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
    next_exp = lit ? lit_exp : model(d, int'(s), op);
    acc = 1'b0;
    for (int k = 0; k < 32 && !acc; k++) begin
      step(took);
      acc = took;
    end
    checks++;
    assert (acc) else begin
      fails++;
      $error("FAIL accept_timeout: observed no accept expected accept within 32 cycles");
    end
  endtask

  task automatic idle(input int n);
    bit took;
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) step(took);
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
`ifdef SHIFT_FLAGS_EN
    check("rst_zero", 32'(out_zero), 32'd0);
    check("rst_carry", 32'(out_carry), 32'd0);
`endif
    rst_n = 1'b1;
    idle(2);

    // Directed vectors with hand-derived results {carry, data}
    lat_check = 1'b1;
    send(8'h0F, 4'd2,  3'd0, 1'b1, {1'b0, 8'h3C});
    send(8'hF0, 4'd2,  3'd1, 1'b1, {1'b0, 8'h3C});
    send(8'hF0, 4'd2,  3'd3, 1'b1, {1'b0, 8'hFC});
    send(8'h80, 4'd9,  3'd3, 1'b1, {1'b1, 8'hFF});
    send(8'h80, 4'd9,  3'd1, 1'b1, {1'b0, 8'h00});
    send(8'h81, 4'd1,  3'd5, 1'b1, {1'b1, 8'hC0});
    send(8'h81, 4'd9,  3'd4, 1'b1, {1'b1, 8'h03});
    send(8'hA5, 4'd3,  3'd6, 1'b1, {1'b0, 8'hA5});
    send(8'h5A, 4'd0,  3'd4, 1'b1, {1'b0, 8'h5A});
    send(8'h81, 4'd8,  3'd0, 1'b1, {1'b1, 8'h00});
    send(8'h81, 4'd15, 3'd2, 1'b1, {1'b0, 8'h00});
    send(8'h81, 4'd8,  3'd1, 1'b1, {1'b1, 8'h00});
    send(8'h40, 4'd15, 3'd3, 1'b1, {1'b0, 8'h00});
    send(8'h01, 4'd8,  3'd5, 1'b1, {1'b0, 8'h01});
    send(8'h3C, 4'd5,  3'd7, 1'b1, {1'b0, 8'h3C});
    idle(4);

    // Back-to-back random stream, full throughput
    for (int i = 0; i < 16; i++)
      send(8'($urandom), 4'($urandom), 3'($urandom), 1'b0, 9'd0);
    idle(4);

    // Stall for 4 cycles in the middle of a stream
    lat_check = 1'b0;
    saw_block = 1'b0;
    st_start  = cycle + 3;
    st_len    = 4;
    for (int i = 0; i < 12; i++)
      send(8'($urandom), 4'($urandom), 3'($urandom), 1'b0, 9'd0);
    idle(6);
    check("stall_blocked", 32'(saw_block), 32'd1);

    // Random backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 30; i++)
      send(8'($urandom), 4'($urandom), 3'($urandom), 1'b0, 9'd0);
    rand_mode = 1'b0;
    st_len = 0;
    out_ready = 1'b1;
    idle(8);
    check("drain_empty", 32'(q.size()), 32'd0);
    check("no_loss", 32'(pops), 32'(pushes));

    // Asynchronous reset with both stages full
    st_start = cycle;
    st_len   = 1000;
    out_ready = 1'b0;
    send(8'h12, 4'd1, 3'd0, 1'b0, 9'd0);
    send(8'h34, 4'd2, 3'd1, 1'b0, 9'd0);
    in_valid = 1'b0;
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_out_data", 32'(out_data), 32'd0);
    q.delete();
    hold_pend = 1'b0;
    st_len = 0;
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
